// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: run controller and end-of-program checker for the multicycle CPU.
// It gates the CPU through cpu_en and counts RUN cycles against a budget.
// A run ends on a halt (halt opcode in IR, or PC parked on one value long enough)
// or when the budget runs out. result is compared to expect_value at the halt.
//
// Handshake: start is a single-cycle request that is sampled only in IDLE, DONE
// or TIMEOUT and is ignored in RUN. There is no ready signal: busy=1 means a
// run is in progress. cpu_en/busy rise after the edge that samples start, and
// they fall after the edge that ends the run. Every output is a register.
module cpu_run_monitor #(
  parameter int                WIDTH       = 32,
  parameter int                CYCLE_W     = 16,
  parameter int                MAX_CYCLES  = 85,
  parameter logic [WIDTH-1:0]  HALT_INSTR  = 32'hFC00_0000,
  parameter int                STALL_LIMIT = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   PC,
  input  logic [WIDTH-1:0]   IR,
  input  logic [WIDTH-1:0]   result,
  input  logic [WIDTH-1:0]   expect_value,
  output logic               cpu_en,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic               pass,
  output logic               fail,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic [1:0]         state_dbg
);

  localparam int STALL_W = $clog2(STALL_LIMIT + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);
  localparam logic [CYCLE_W-1:0] CYCLE_MAX = CYCLE_W'(MAX_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_DONE    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [STALL_W-1:0] stall_cnt, stall_n;
  logic [WIDTH-1:0]   pc_prev, pc_prev_n;
  logic [CYCLE_W-1:0] cycle_n;
  logic               cpu_en_n, busy_n, done_n, timeout_n, pass_n, fail_n;
  logic               pc_same, halt_hit, budget_hit, result_ok;

  assign state_dbg = state;

  // Exit detection in RUN. The self-loop test looks at the count before this
  // edge, so the halt fires on the STALL_LIMIT-th consecutive matching edge.
  assign pc_same    = (PC == pc_prev);
  assign halt_hit   = (IR == HALT_INSTR) ||
                      (pc_same && ((stall_cnt + 1'b1) == STALL_MAX));
  assign budget_hit = ((cycle_count + 1'b1) == CYCLE_MAX);
  assign result_ok  = (result == expect_value);

  // State register and all registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cycle_count <= '0;
      stall_cnt   <= '0;
      pc_prev     <= '0;
      cpu_en      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state       <= state_n;
      cycle_count <= cycle_n;
      stall_cnt   <= stall_n;
      pc_prev     <= pc_prev_n;
      cpu_en      <= cpu_en_n;
      busy        <= busy_n;
      done        <= done_n;
      timeout     <= timeout_n;
      pass        <= pass_n;
      fail        <= fail_n;
    end
  end

  // Next state and the next values of every registered output
  always_comb begin
    state_n   = state;
    cycle_n   = cycle_count;
    stall_n   = stall_cnt;
    pc_prev_n = pc_prev;
    cpu_en_n  = 1'b0;
    busy_n    = 1'b0;
    done_n    = done;
    timeout_n = timeout;
    pass_n    = pass;
    fail_n    = fail;

    case (state)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        // IDLE keeps everything clear. DONE/TIMEOUT keep the last verdict
        // on show until a new start arrives.
        if (state == S_IDLE || start) begin
          cycle_n   = '0;
          stall_n   = '0;
          pc_prev_n = PC;
          done_n    = 1'b0;
          timeout_n = 1'b0;
          pass_n    = 1'b0;
          fail_n    = 1'b0;
        end
        if (start) begin
          state_n  = S_RUN;
          cpu_en_n = 1'b1;
          busy_n   = 1'b1;
        end
      end

      S_RUN: begin
        cycle_n   = cycle_count + 1'b1;
        stall_n   = pc_same ? (stall_cnt + 1'b1) : '0;
        pc_prev_n = PC;
        cpu_en_n  = 1'b1;
        busy_n    = 1'b1;
        if (halt_hit) begin
          // A halt beats budget exhaustion on the same edge
          state_n  = S_DONE;
          cpu_en_n = 1'b0;
          busy_n   = 1'b0;
          done_n   = 1'b1;
          pass_n   = result_ok;
          fail_n   = !result_ok;
        end else if (budget_hit) begin
          state_n   = S_TIMEOUT;
          cpu_en_n  = 1'b0;
          busy_n    = 1'b0;
          timeout_n = 1'b1;
          fail_n    = 1'b1;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// tb_cpu_run_monitor: directed bench for cpu_run_monitor with hand-computed expectations.
`timescale 1ns/1ps
module tb_cpu_run_monitor;

  localparam logic [31:0] HALT = 32'hFC00_0000;
  localparam logic [31:0] NOP  = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] PC = '0;
  logic [31:0] IR = '0;
  logic [31:0] result = '0;
  logic [31:0] expect_value = '0;
  logic        cpu_en, busy, done, timeout, pass, fail;
  logic [15:0] cycle_count;
  logic [1:0]  state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_run_monitor #(
    .WIDTH(32), .CYCLE_W(16), .MAX_CYCLES(85),
    .HALT_INSTR(32'hFC00_0000), .STALL_LIMIT(8)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .PC(PC), .IR(IR),
    .result(result), .expect_value(expect_value), .cpu_en(cpu_en),
    .busy(busy), .done(done), .timeout(timeout), .pass(pass), .fail(fail),
    .cycle_count(cycle_count), .state_dbg(state_dbg)
  );

  // Clock and reset block
  always #5 clock = ~clock;

  // Checking task: every comparison goes through here
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change 1ns after the rising edge, outputs sampled there too
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start();
    PC    = 32'h0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_edge(input logic [31:0] pc, input logic [31:0] ir);
    PC = pc;
    IR = ir;
    tick();
    IR = NOP;
  endtask

  // Distinct PC per RUN edge so no accidental self-loop
  function automatic logic [31:0] pc_of(input int k);
    return 32'h1000 + 32'(4 * k);
  endfunction

  task automatic check_flags(input string tag, input logic d, input logic t,
                             input logic p, input logic f, input int cyc);
    check({tag, "_done"},    32'(done),        32'(d));
    check({tag, "_timeout"}, 32'(timeout),     32'(t));
    check({tag, "_pass"},    32'(pass),        32'(p));
    check({tag, "_fail"},    32'(fail),        32'(f));
    check({tag, "_cycles"},  32'(cycle_count), 32'(cyc));
    check({tag, "_cpu_en"},  32'(cpu_en),      32'(0));
    check({tag, "_busy"},    32'(busy),        32'(0));
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    reset = 1'b0;
    check("rst_cpu_en", 32'(cpu_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_flags", 32'({done, timeout, pass, fail}), 0);
    check("rst_cycles", 32'(cycle_count), 0);
    check("rst_state", 32'(state_dbg), 0);
    tick();
    check("idle_stays", 32'(state_dbg), 0);

    // Start latency, then asynchronous reset mid-run after 10 RUN edges
    do_start();
    check("start_cpu_en", 32'(cpu_en), 1);
    check("start_busy", 32'(busy), 1);
    check("start_cycles", 32'(cycle_count), 0);
    for (int k = 1; k <= 10; k++) run_edge(pc_of(k), NOP);
    check("pre_rst_cycles", 32'(cycle_count), 10);
    check("pre_rst_busy", 32'(busy), 1);
    #3 reset = 1'b1;
    #1;
    check("async_rst_cpu_en", 32'(cpu_en), 0);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_cycles", 32'(cycle_count), 0);
    check("async_rst_state", 32'(state_dbg), 0);
    #1 reset = 1'b0;
    tick();
    check("post_rst_idle", 32'(busy), 0);
    // A run after the reset behaves normally; end it with an IR halt on edge 3
    result = 32'h5; expect_value = 32'h5;
    do_start();
    check("rerun_busy", 32'(busy), 1);
    run_edge(pc_of(1), NOP);
    run_edge(pc_of(2), NOP);
    run_edge(pc_of(3), HALT);
    check_flags("rerun", 1, 0, 1, 0, 3);

    // IR halt on RUN edge 20 with matching result; a start in RUN is ignored
    result = 32'h37; expect_value = 32'h37;
    do_start();
    check("restart_clears_done", 32'(done), 0);
    check("restart_clears_pass", 32'(pass), 0);
    for (int k = 1; k <= 19; k++) begin
      start = (k == 5);
      run_edge(pc_of(k), NOP);
      start = 1'b0;
      if (k == 5) begin
        check("start_in_run_cycles", 32'(cycle_count), 5);
        check("start_in_run_busy", 32'(busy), 1);
      end
    end
    check("pre_halt_busy", 32'(busy), 1);
    run_edge(pc_of(20), HALT);
    check_flags("halt_pass", 1, 0, 1, 0, 20);
    run_edge(pc_of(21), NOP);
    check("done_holds_cycles", 32'(cycle_count), 20);
    check("done_holds_flag", 32'(done), 1);

    // Same but result mismatch
    result = 32'h36;
    do_start();
    for (int k = 1; k <= 19; k++) run_edge(pc_of(k), NOP);
    run_edge(pc_of(20), HALT);
    check_flags("halt_fail", 1, 0, 0, 1, 20);

    // Budget exhaustion with PC toggling
    result = 32'h37;
    do_start();
    for (int k = 1; k <= 84; k++) run_edge((k % 2 == 1) ? 32'h4 : 32'h8, NOP);
    check("pre_timeout_busy", 32'(busy), 1);
    check("pre_timeout_flag", 32'(timeout), 0);
    run_edge(32'h4, NOP);
    check_flags("timeout", 0, 1, 0, 1, 85);
    check("timeout_state", 32'(state_dbg), 3);

    // Self-loop halt: PC parked at 0x40 from edge 30 halts on edge 38
    do_start();
    for (int k = 1; k <= 29; k++) run_edge(pc_of(k), NOP);
    for (int k = 30; k <= 37; k++) run_edge(32'h40, NOP);
    check("stall_37_not_done", 32'(done), 0);
    check("stall_37_busy", 32'(busy), 1);
    run_edge(32'h40, NOP);
    check_flags("stall_halt", 1, 0, 1, 0, 38);

    // Short holds (5 edges, then 8 edges) never halt; finish with IR halt
    do_start();
    for (int k = 1; k <= 9; k++) run_edge(pc_of(k), NOP);
    for (int k = 10; k <= 14; k++) run_edge(32'h40, NOP);
    for (int k = 15; k <= 19; k++) run_edge(pc_of(k), NOP);
    check("hold5_no_halt", 32'(done), 0);
    for (int k = 20; k <= 27; k++) run_edge(32'h80, NOP);
    check("hold8_no_halt", 32'(done), 0);
    for (int k = 28; k <= 39; k++) run_edge(pc_of(k), NOP);
    check("holds_still_busy", 32'(busy), 1);
    check("holds_cycles", 32'(cycle_count), 39);
    run_edge(pc_of(40), HALT);
    check_flags("holds_halt", 1, 0, 1, 0, 40);

    // Halt and budget on the same edge 85: halt wins
    do_start();
    for (int k = 1; k <= 84; k++) run_edge(pc_of(k), NOP);
    run_edge(pc_of(85), HALT);
    check_flags("coincide", 1, 0, 1, 0, 85);
    // start from DONE clears flags and counts from 1
    do_start();
    check("restart_done", 32'(done), 0);
    check("restart_cycles", 32'(cycle_count), 0);
    check("restart_busy", 32'(busy), 1);
    run_edge(pc_of(1), NOP);
    check("restart_first_edge", 32'(cycle_count), 1);
    check("restart_no_fail", 32'(fail), 0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_run_monitor.md
# cpu_run_monitor

Synthesizable run controller and end-of-program checker for the multicycle CPU. It gates the CPU with a clock enable and counts executed clock cycles against a parametrised budget. It detects program completion by a halt opcode or by a PC self-loop, and it reports pass/fail by comparing the CPU's result register against an expected value. It sits beside `CPU` in the top level and in the CPU bench, replacing the fixed clock-repeat count with a bounded, self-terminating run.

## Interface

Parameters:

- `WIDTH`, 32: width of `PC`, `IR`, `result`, `expect_value`.
- `CYCLE_W`, 16: width of `cycle_count`.
- `MAX_CYCLES`, 85: cycle budget per run; must be ≥ 1 and < 2^CYCLE_W.
- `HALT_INSTR`, 32'hFC00_0000: instruction word that terminates a run.
- `STALL_LIMIT`, 8: consecutive unchanged-PC cycles that count as a self-loop halt; must exceed the longest instruction's cycle count.

Ports:

- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; one clock, reset is asynchronous and active-high.
- `start` in 1: one-cycle pulse that begins a run.
- `PC` in WIDTH: CPU program counter.
- `IR` in WIDTH: CPU instruction register.
- `result` in WIDTH: CPU result register (reg8).
- `expect_value` in WIDTH: expected final `result`.
- `cpu_en` out 1: CPU clock enable.
- `busy` out 1: high while in RUN.
- `done` out 1: run ended by halt.
- `timeout` out 1: run ended by budget exhaustion.
- `pass` out 1: done and result matched.
- `fail` out 1: timeout, or done with mismatch.
- `cycle_count` out CYCLE_W: cycles spent in RUN.

## Operation

- States: IDLE, RUN, DONE, TIMEOUT. All outputs are registered.
- Reset (asynchronous): state IDLE, all outputs 0, `cycle_count` 0, internal `pc_prev` 0, `stall_cnt` 0.
- IDLE:
  - `start` → RUN.
  - Clear `cycle_count`, `stall_cnt`, `pass`, `fail`, `done`, `timeout`.
  - Load `pc_prev` ← `PC`.
- RUN, evaluated each edge:
  - `cpu_en`=1 and `busy`=1.
  - `cycle_count` += 1.
  - `stall_cnt` ← (`PC`==`pc_prev`) ? `stall_cnt`+1 : 0.
  - `pc_prev` ← `PC`.
- Exit conditions from RUN, priority high→low:
  1. Halt: `IR`==`HALT_INSTR`, or `stall_cnt`+1 == `STALL_LIMIT` with `PC`==`pc_prev` → DONE. Set `done`=1. Set `pass`=(`result`==`expect_value`) and `fail`=!pass, sampled on that edge.
  2. Budget: `cycle_count`+1 == `MAX_CYCLES` → TIMEOUT. Set `timeout`=1 and `fail`=1.
- Halt and budget on the same edge: halt wins.
- DONE / TIMEOUT:
  - `cpu_en`=0, `busy`=0.
  - Flags and `cycle_count` hold.
  - `start` → RUN with the same clears as from IDLE.
- `start` while in RUN is ignored.
- Arithmetic: `stall_cnt` is ⌈log2(STALL_LIMIT+1)⌉ bits and never exceeds `STALL_LIMIT`. `cycle_count` cannot wrap because of the MAX_CYCLES bound.
- `pass` and `fail` are never both 1. Exactly one of `done`/`timeout` is set per completed run.

## Timing

- Start latency: `start` sampled on edge N → `cpu_en`=`busy`=1 after edge N. The CPU's first enabled edge is N+1.
- `cycle_count` after the last RUN edge equals the number of RUN edges, including the terminating edge.
- Timeout occurs on exactly the `MAX_CYCLES`th RUN edge; `cycle_count`=`MAX_CYCLES` thereafter.
- Halt via `IR` is detected on the first RUN edge where `IR` shows the halt word. `cpu_en` drops after that edge, so the CPU sees no further enabled edges.
- Self-loop halt occurs on the edge where PC has matched `pc_prev` for `STALL_LIMIT` consecutive RUN edges.
- `reset` asserted mid-run: immediate return to IDLE with outputs 0. It takes effect on the `reset` edge, not on `clock`.

## Test plan

- Reset mid-run at cycle 10 → `cpu_en`, `busy`, `cycle_count` go to 0 without a clock edge; a subsequent `start` runs normally.
- Start, then `IR`=HALT_INSTR on RUN edge 20 with `result`=`expect_value`=32'h0000_0037 → `done`=1, `pass`=1, `fail`=0, `cycle_count`=20, `cpu_en`=0.
- Same as above but `result`=32'h0000_0036 → `done`=1, `pass`=0, `fail`=1.
- PC toggles, never halts, `MAX_CYCLES`=85 → `timeout`=1, `fail`=1, `cycle_count`=85, `done`=0.
- PC held at 32'h0000_0040 from RUN edge 30 with `STALL_LIMIT`=8 → `done` after edge 38, `cycle_count`=38. The same PC held for only 5 edges, then changing, does not halt.
- Halt and budget coincide on edge 85 → `done`=1, `timeout`=0. Then `start` in DONE → flags clear, new run counts from 1.
